// File: rtl/imem_loader.sv
// Program loader and instruction RAM: receives a length-prefixed big-endian byte stream,
// fills the word RAM, holds the core in reset while loading and serves combinational fetches.
module imem_loader #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [31:0]          rdata,
    input  logic                 core_halted,
    output logic                 core_reset,
    output logic                 load_done,
    output logic                 overflow,
    output logic [ADDR_SIZE:0]   words_loaded
);

    localparam int unsigned DEPTH = 1 << ADDR_SIZE;

    typedef enum logic [1:0] {
        S_HDR,
        S_DATA,
        S_RUN,
        S_HALTED
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [23:0]         asm_q, asm_d;
    logic [31:0]         n_q, n_d;
    logic [31:0]         wcnt_q, wcnt_d;
    logic                ovf_q, ovf_d;
    logic [ADDR_SIZE:0]  wl_q, wl_d;

    logic [31:0]          mem [DEPTH];
    logic                 we;
    logic [ADDR_SIZE-1:0] waddr;
    logic [31:0]          word;
    logic                 accept;

    assign accept = in_valid && in_ready;
    assign word   = {asm_q, in_data};

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        n_d     = n_q;
        wcnt_d  = wcnt_q;
        ovf_d   = ovf_q;
        wl_d    = wl_q;
        we      = 1'b0;
        waddr   = wcnt_q[ADDR_SIZE-1:0];

        case (state_q)
            S_HDR, S_DATA: begin
                if (accept) begin
                    if (bcnt_q != 2'd3) begin
                        asm_d  = {asm_q[15:0], in_data};
                        bcnt_d = bcnt_q + 2'd1;
                    end else begin
                        bcnt_d = 2'd0;
                        if (state_q == S_HDR) begin
                            n_d     = word;
                            wcnt_d  = '0;
                            ovf_d   = (word > DEPTH);
                            state_d = (word == 32'd0) ? S_RUN : S_DATA;
                        end else begin
                            // Words past the RAM depth are consumed but not stored.
                            if (wcnt_q < DEPTH) begin
                                we   = 1'b1;
                                wl_d = wl_q + (ADDR_SIZE+1)'(1);
                            end
                            wcnt_d = wcnt_q + 32'd1;
                            if (wcnt_q == n_q - 32'd1) begin
                                state_d = S_RUN;
                            end
                        end
                    end
                end
            end
            S_RUN: begin
                if (core_halted) begin
                    state_d = S_HALTED;
                end
            end
            S_HALTED: begin
                // The accepted byte is already header byte 0 of the next load.
                if (accept) begin
                    state_d = S_HDR;
                    asm_d   = {asm_q[15:0], in_data};
                    bcnt_d  = 2'd1;
                    wcnt_d  = '0;
                    ovf_d   = 1'b0;
                    wl_d    = '0;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_HDR;
            bcnt_q  <= '0;
            asm_q   <= '0;
            n_q     <= '0;
            wcnt_q  <= '0;
            ovf_q   <= 1'b0;
            wl_q    <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            n_q     <= n_d;
            wcnt_q  <= wcnt_d;
            ovf_q   <= ovf_d;
            wl_q    <= wl_d;
        end
    end

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= word;
        end
    end

    assign rdata        = mem[raddr];
    assign in_ready     = (state_q != S_RUN);
    assign core_reset   = (state_q == S_HDR) || (state_q == S_DATA);
    assign load_done    = (state_q == S_RUN) || (state_q == S_HALTED);
    assign overflow     = ovf_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a full-size instance and a 4-word instance
// share one byte stream; written words are checked through a scoreboard queue.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        core_halted = 1'b0;

    logic        in_ready, core_reset, load_done, overflow;
    logic [7:0]  raddr = '0;
    logic [31:0] rdata;
    logic [8:0]  words_loaded;

    logic        in_ready_s, core_reset_s, load_done_s, overflow_s;
    logic [1:0]  raddr_s = '0;
    logic [31:0] rdata_s;
    logic [2:0]  words_loaded_s;

    imem_loader #(.ADDR_SIZE(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .raddr(raddr), .rdata(rdata), .core_halted(core_halted),
        .core_reset(core_reset), .load_done(load_done), .overflow(overflow),
        .words_loaded(words_loaded)
    );

    imem_loader #(.ADDR_SIZE(2)) dut_s (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_s), .raddr(raddr_s), .rdata(rdata_s), .core_halted(core_halted),
        .core_reset(core_reset_s), .load_done(load_done_s), .overflow(overflow_s),
        .words_loaded(words_loaded_s)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        exp_s_q[$];
    logic [31:0] load_words[$];
    logic [31:0] model_mem [256];
    bit          model_vld [256];
    int          n_checks = 0;
    int          n_fail = 0;
    int          acc_cnt = 0;

    always @(posedge clock) begin
        if (!reset && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int unsigned guard = 0;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic pre_done_check();
        check("pre_core_reset", {31'd0, core_reset}, 32'd1);
        check("pre_load_done", {31'd0, load_done}, 32'd0);
    endtask

    task automatic drain_scoreboard();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            raddr = e.addr;
            #1 check("ram_word", rdata, e.data);
        end
        while (exp_s_q.size() > 0) begin
            e = exp_s_q.pop_front();
            raddr_s = e.addr[1:0];
            #1 check("ram_word_s", rdata_s, e.data);
        end
    endtask

    task automatic send_load(input int unsigned n, input bit gaps);
        logic [31:0] hdr;
        logic [31:0] w;
        exp_t        e;
        hdr = n;
        for (int unsigned b = 0; b < 4; b++) begin
            if (n == 0 && b == 3) pre_done_check();
            send_byte(hdr[31-8*b -: 8], gaps);
        end
        for (int unsigned i = 0; i < n; i++) begin
            w = load_words[i];
            for (int unsigned b = 0; b < 4; b++) begin
                if (b == 3) begin
                    raddr = i[7:0];
                    #1;
                    if (i < 256 && model_vld[i]) check("ram_old_before_edge", rdata, model_mem[i]);
                    if (i == n - 1) pre_done_check();
                end
                send_byte(w[31-8*b -: 8], gaps);
            end
            if (i < 256) begin
                e.addr = i[7:0];
                e.data = w;
                exp_q.push_back(e);
                model_mem[i] = w;
                model_vld[i] = 1'b1;
            end
            if (i < 4) exp_s_q.push_back(e);
            drain_scoreboard();
        end
        in_valid = 1'b0;
        check("done_core_reset", {31'd0, core_reset}, 32'd0);
        check("done_load_done", {31'd0, load_done}, 32'd1);
    endtask

    task automatic halt_core();
        core_halted = 1'b1;
        @(posedge clock);
        @(negedge clock);
        core_halted = 1'b0;
        check("halt_in_ready", {31'd0, in_ready}, 32'd1);
        check("halt_load_done", {31'd0, load_done}, 32'd1);
        check("halt_core_reset", {31'd0, core_reset}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        logic [31:0] hw;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_core_reset", {31'd0, core_reset}, 32'd1);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_words_loaded", {23'd0, words_loaded}, 32'd0);

        // Normal back-to-back load
        load_words.delete();
        load_words.push_back(32'h2002_0005);
        load_words.push_back(32'h0042_1020);
        load_words.push_back(32'h0000_000D);
        a0 = acc_cnt;
        send_load(3, 1'b0);
        check("normal_accepts", acc_cnt - a0, 32'd16);
        check("normal_words_loaded", {23'd0, words_loaded}, 32'd3);
        check("normal_overflow", {31'd0, overflow}, 32'd0);

        // Bytes offered while running must not be taken
        a0 = acc_cnt;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (3) begin
            @(negedge clock);
            check("run_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        check("run_no_accept", acc_cnt - a0, 32'd0);
        check("run_core_reset", {31'd0, core_reset}, 32'd0);
        halt_core();

        // Empty program reloaded from HALTED
        send_byte(8'h00, 1'b0);
        check("reload_core_reset", {31'd0, core_reset}, 32'd1);
        check("reload_words_cleared", {23'd0, words_loaded}, 32'd0);
        hw = 32'h0;
        for (int unsigned b = 1; b < 4; b++) begin
            if (b == 3) pre_done_check();
            send_byte(hw[31-8*b -: 8], 1'b0);
        end
        in_valid = 1'b0;
        check("n0_load_done", {31'd0, load_done}, 32'd1);
        check("n0_core_reset", {31'd0, core_reset}, 32'd0);
        check("n0_words_loaded", {23'd0, words_loaded}, 32'd0);
        check("n0_overflow", {31'd0, overflow}, 32'd0);
        raddr = 8'd0;
        #1 check("n0_mem0_kept", rdata, model_mem[0]);
        halt_core();

        // Gapped two-word load
        load_words.delete();
        load_words.push_back($urandom);
        load_words.push_back($urandom);
        a0 = acc_cnt;
        send_load(2, 1'b1);
        check("gap_accepts", acc_cnt - a0, 32'd12);
        check("gap_words_loaded", {23'd0, words_loaded}, 32'd2);
        raddr = 8'd2;
        #1 check("gap_mem2_kept", rdata, model_mem[2]);
        halt_core();

        // Overflow: six words into the 4-word instance
        load_words.delete();
        for (int unsigned i = 1; i <= 6; i++) load_words.push_back(i);
        a0 = acc_cnt;
        send_load(6, 1'b0);
        check("ovf_accepts", acc_cnt - a0, 32'd28);
        check("ovf_flag_s", {31'd0, overflow_s}, 32'd1);
        check("ovf_words_loaded_s", {29'd0, words_loaded_s}, 32'd4);
        check("ovf_flag_big", {31'd0, overflow}, 32'd0);
        check("ovf_words_loaded_big", {23'd0, words_loaded}, 32'd6);
        check("ovf_done_s", {31'd0, load_done_s}, 32'd1);
        for (int unsigned i = 0; i < 4; i++) begin
            raddr_s = i[1:0];
            #1 check("ovf_mem_s", rdata_s, i + 1);
        end
        halt_core();

        // Reset in the middle of word 1 of a 3-word load
        send_byte(8'h00, 1'b0);
        check("hdr_entry_overflow_s", {31'd0, overflow_s}, 32'd0);
        check("hdr_entry_words", {23'd0, words_loaded}, 32'd0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        for (int unsigned b = 0; b < 4; b++) send_byte(8'h11, 1'b0);
        model_mem[0] = 32'h1111_1111;
        send_byte(8'h22, 1'b0);
        send_byte(8'h22, 1'b0);
        in_data = 8'h77;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_core_reset", {31'd0, core_reset}, 32'd1);
        check("mid_rst_load_done", {31'd0, load_done}, 32'd0);
        check("mid_rst_words", {23'd0, words_loaded}, 32'd0);
        raddr = 8'd0;
        #1 check("mid_rst_word0_kept", rdata, 32'h1111_1111);
        load_words.delete();
        load_words.push_back(32'hAABB_CCDD);
        send_load(1, 1'b0);
        check("after_rst_words", {23'd0, words_loaded}, 32'd1);
        for (int unsigned i = 1; i < 4; i++) begin
            raddr = i[7:0];
            #1 check("after_rst_kept", rdata, model_mem[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
